// File: rtl/sort_result_serializer.sv
// ============================================================================
//  Module      : sort_result_serializer
//  Description : Captures one sorted N-element vector and streams it out one
//                element per valid/ready handshake, with out_last on the final
//                element. Optional macro SORT_ORDER_CHECK_EN adds order_err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sort_result_serializer #(
   parameter int N          = 4,
   parameter int WIDTH      = 32,
   parameter int DESCENDING = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_last,
   output logic               busy
`ifdef SORT_ORDER_CHECK_EN
   ,
   output logic               order_err
`endif
);

   localparam int c_IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(N - 1);
   localparam logic [c_IW-1:0] c_FIRST_IDX = (DESCENDING != 0) ? c_LAST_IDX : '0;
   localparam logic [c_IW-1:0] c_FINAL_IDX = (DESCENDING != 0) ? '0 : c_LAST_IDX;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N*WIDTH-1:0] r_buf;
   logic [c_IW-1:0]    r_idx;
   logic [c_IW-1:0]    w_idx_nxt;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic               r_out_last;
   logic               w_capture;
   logic               w_handshake;

   function automatic logic [WIDTH-1:0] elem(input logic [N*WIDTH-1:0] v,
                                             input logic [c_IW-1:0] i);
      return v[WIDTH*int'(i) +: WIDTH];
   endfunction

   assign w_idx_nxt = (DESCENDING != 0) ? (r_idx - c_IW'(1)) : (r_idx + c_IW'(1));

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      w_capture   = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready  = 1'b1;
            w_capture = in_valid;
            if (in_valid)
               w_state_nxt = S_STREAM;
         end
         S_STREAM: begin
            busy        = 1'b1;
            w_handshake = r_out_valid & out_ready;
            if (w_handshake && r_out_last)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output element is registered from the buffer so out_data never glitches
   // while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_buf       <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_buf       <= in_data;
            r_idx       <= c_FIRST_IDX;
            r_out_valid <= 1'b1;
            r_out_data  <= elem(in_data, c_FIRST_IDX);
            r_out_last  <= (c_FIRST_IDX == c_FINAL_IDX);
         end else if (w_handshake) begin
            if (r_out_last) begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
            end else begin
               r_idx      <= w_idx_nxt;
               r_out_data <= elem(r_buf, w_idx_nxt);
               r_out_last <= (w_idx_nxt == c_FINAL_IDX);
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;

`ifdef SORT_ORDER_CHECK_EN
   logic w_order_bad;
   logic r_order_err;

   always_comb begin
      w_order_bad = 1'b0;
      for (int i = 0; i < N - 1; i++) begin
         if (in_data[WIDTH*i +: WIDTH] > in_data[WIDTH*(i+1) +: WIDTH])
            w_order_bad = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_order_err <= 1'b0;
      else if (w_capture)
         r_order_err <= w_order_bad;
   end

   assign order_err = r_order_err;
`endif

endmodule

`default_nettype wire

// File: doc/sort_result_serializer.md
Name: sort_result_serializer

Overview:
Output end of the odd-even transposition sorter.
- Accepts one fully sorted N-element vector from the PE chain in a single valid/ready handshake.
- Streams the elements out one per handshake on a valid/ready/last interface toward the consumer.
- Frees the sorter array for reload as soon as the vector is captured.

Parameters:
N, 4, number of elements per vector (>=1)
WIDTH, 32, element width in bits; matches the PE datapath
DESCENDING, 0, 0 = emit element 0 first (smallest); 1 = emit element N-1 first (largest)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  sorted vector available
in_ready  output  1  block can capture a vector
in_data  input  N*WIDTH  sorted vector; element i at bits [WIDTH*i+WIDTH-1 : WIDTH*i], element 0 is the smallest
out_valid  output  1  out_data holds a valid element
out_ready  input  1  consumer accepts element
out_data  output  WIDTH  current element
out_last  output  1  current element is the final one of the vector
busy  output  1  vector held, streaming in progress

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high, sampled on the rising edge of clk.
- State machine: two states, IDLE and STREAM.
  - in_ready = (state == IDLE), decoded from state only.
  - busy = (state == STREAM).
- Reset values: state IDLE, out_valid 0, out_data 0, out_last 0, index 0, capture register 0. Hence in_ready = 1 and busy = 0.
- Capture (IDLE, in_valid = 1):
  - The whole in_data is registered into the capture buffer.
  - Index is set to 0, or to N-1 when DESCENDING = 1.
  - State becomes STREAM.
  - out_valid = 1 from the next cycle, with out_data = first element. Latency is one cycle.
- STREAM, on handshake (out_valid & out_ready):
  - Index steps +1 (ascending) or -1 (descending).
  - out_data updates to the next element on the next cycle.
- STREAM, no handshake (out_valid & !out_ready): out_data, out_last and index hold stable. No element is dropped or repeated.
- out_last:
  - High exactly while the final element is presented: index N-1 ascending, index 0 descending.
  - Asserted together with out_valid.
- End of vector:
  - A handshake with out_last = 1 returns the block to IDLE on the next cycle.
  - out_valid and out_last go to 0 that cycle; in_ready is 1 that cycle.
- No overlap: a new vector is never captured in the same cycle as the last output handshake.
  - Full-rate throughput is N+1 cycles per vector.
- N = 1: single element presented with out_last = 1 immediately.
- Capture buffer ownership: the buffer is written only in IDLE. in_data changes during STREAM are ignored.
- in_valid in STREAM: ignored. in_ready is low, so no handshake occurs.
- Reset mid-stream: the held vector is discarded. Next cycle: IDLE, out_valid 0, index 0.
- Index width: clog2(N), with a minimum of 1 bit. Index never leaves 0..N-1; it does not wrap.
- Element values: passed through unmodified; no arithmetic on data.

Optional Feature:
Macro: SORT_ORDER_CHECK_EN
- Defined:
  - Adds output port order_err (1 bit, reset 0).
  - At capture, the block checks every adjacent pair with an unsigned compare, using the same compare as the PE. If any element i > element i+1, order_err = 1 from the cycle after capture.
  - order_err stays high through the stream until the next capture (re-evaluated) or rst.
  - Streaming proceeds unchanged regardless of order_err.
- Not defined: port order_err and all compare logic are absent. Behaviour is otherwise identical.

Test Plan:
1. Ascending, no backpressure: rst, then capture {1,5,9,12} (element 0 = 1) with out_ready held 1.
   - out_data 1,5,9,12 on 4 consecutive cycles.
   - out_last only on 12.
   - in_ready = 1 on the cycle after 12.
2. Backpressure: same vector, out_ready low for 3 cycles while 5 is shown.
   - out_data holds 5 and out_valid stays 1.
   - Stream resumes with 9; exactly 4 handshakes total.
3. DESCENDING = 1, vector {0x0,0x10,0xFFFFFFFF,0xFFFFFFFF}: emits 0xFFFFFFFF, 0xFFFFFFFF, 0x10, 0x0, with out_last on 0x0.
4. Reset mid-stream: assert rst after 2 handshakes.
   - Next cycle: out_valid 0, in_ready 1.
   - A following vector {2,3,4,7} streams from 2 with no stale data.
5. Input change ignored / N = 1:
   - in_data changed to all-0xAAAAAAAA during STREAM: output is unaffected.
   - N = 1 build, capture 42: out_data 42 with out_last = 1 one cycle later.
6. With SORT_ORDER_CHECK_EN defined:
   - Capture {3,2,8,9}: order_err = 1 the cycle after capture and held through the stream.
   - Next capture {1,2,3,4}: order_err clears.
